// File: rtl/mux16_scan_ctrl.sv
// mux16_scan_ctrl: steps a 16:1 mux select through all channels, samples each
// after a settle window and hands the assembled word out on valid/ready.
module mux16_scan_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        cont_i,
    input  logic        mux_out_i,
    input  logic        ready_i,
    output logic [3:0]  sel_o,
    output logic [15:0] data_o,
    output logic        valid_o,
    output logic        busy_o
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
    // With no settle time every channel is sampled on consecutive edges.
    localparam state_t FIRST = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
    state_t      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        start_scan;
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        valid_d    = valid_q;
        start_scan = 1'b0;
        case (state_q)
            S_IDLE: start_scan = start_i;
            S_SETTLE: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q <= 4'd1) ? S_SAMPLE : S_SETTLE;
            end
            S_SAMPLE: begin
                data_d[sel_q] = mux_out_i;
                if (sel_q == 4'd15) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                end else begin
                    sel_d   = sel_q + 4'd1;
                    cnt_d   = SETTLE_INIT;
                    state_d = FIRST;
                end
            end
            S_DONE: begin
                if (ready_i) begin
                    valid_d    = 1'b0;
                    start_scan = cont_i || start_i;
                    state_d    = S_IDLE;
                    sel_d      = 4'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Acceptance with restart chains straight into the next scan.
        if (start_scan) begin
            sel_d   = 4'd0;
            data_d  = 16'd0;
            cnt_d   = SETTLE_INIT;
            state_d = FIRST;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= 4'd0;
            cnt_q   <= 4'd0;
            data_q  <= 16'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end
    assign sel_o   = sel_q;
    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign busy_o  = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// tb_mux16_scan_ctrl: two scanners (settle 0 and settle 1) each behind an ideal
// 16:1 mux, checked cycle by cycle against a timing/sampling model.
module tb_mux16_scan_ctrl;
    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       start, cont, ready, mux_out, valid, busy;
    logic [1:0][3:0]  sel;
    logic [1:0][15:0] data, pat;
    logic [15:0]      w;
    int               checks = 0;
    int               failures = 0;

    always #5 clk = ~clk;

    assign mux_out[0] = pat[0][sel[0]];
    assign mux_out[1] = pat[1][sel[1]];

    mux16_scan_ctrl #(.SETTLE_CYCLES(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start_i(start[0]), .cont_i(cont[0]),
        .mux_out_i(mux_out[0]), .ready_i(ready[0]), .sel_o(sel[0]),
        .data_o(data[0]), .valid_o(valid[0]), .busy_o(busy[0])
    );
    mux16_scan_ctrl #(.SETTLE_CYCLES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start_i(start[1]), .cont_i(cont[1]),
        .mux_out_i(mux_out[1]), .ready_i(ready[1]), .sel_o(sel[1]),
        .data_o(data[1]), .valid_o(valid[1]), .busy_o(busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic trig(input int idx);
        start[idx] = 1'b1;
        step();
        start[idx] = 1'b0;
    endtask

    // Called just after the edge that began a scan on instance idx (settle = idx).
    // After m edges Sel should read m/(settle+1); channel k is sampled at edge
    // (k+1)*(settle+1) with whatever pattern the mux shows just before that edge.
    task automatic do_scan(input int idx, input logic [15:0] p0, input logic [15:0] p1,
                           input int chg, input int ig1, input int ig2,
                           output logic [15:0] word);
        int len;
        int k;
        len = 16 * (idx + 1);
        word = '0;
        pat[idx] = p0;
        for (int m = 0; m < len; m++) begin
            chk("scan_sel", 32'(sel[idx]), 32'(m / (idx + 1)));
            chk("scan_busy", 32'(busy[idx]), 32'd1);
            chk("scan_valid_lo", 32'(valid[idx]), 32'd0);
            if (m == chg) pat[idx] = p1;
            start[idx] = (m == ig1) || (m == ig2);
            if ((m + 1) % (idx + 1) == 0) begin
                k = (m + 1) / (idx + 1) - 1;
                word[k] = pat[idx][k];
            end
            step();
        end
        start[idx] = 1'b0;
        chk("done_valid", 32'(valid[idx]), 32'd1);
        chk("done_busy", 32'(busy[idx]), 32'd0);
        chk("done_sel", 32'(sel[idx]), 32'd15);
        chk("done_data", 32'(data[idx]), 32'(word));
    endtask

    task automatic accept(input int idx, input int hold, input logic c, input logic [15:0] word);
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_valid", 32'(valid[idx]), 32'd1);
            chk("hold_data", 32'(data[idx]), 32'(word));
            chk("hold_sel", 32'(sel[idx]), 32'd15);
        end
        cont[idx] = c;
        ready[idx] = 1'b1;
        step();
        chk("acc_valid", 32'(valid[idx]), 32'd0);
        chk("acc_sel", 32'(sel[idx]), 32'd0);
        chk("acc_busy", 32'(busy[idx]), 32'(c));
        chk("acc_data", 32'(data[idx]), c ? 32'd0 : 32'(word));
        if (!c) ready[idx] = 1'b0;
    endtask

    initial begin
        logic [15:0] p0, p1;
        start = '0; cont = '0; ready = '0; pat = '0;
        rst_n = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            chk("rst_sel", 32'(sel[i]), 32'd0);
            chk("rst_data", 32'(data[i]), 32'd0);
            chk("rst_valid", 32'(valid[i]), 32'd0);
            chk("rst_busy", 32'(busy[i]), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_sel", 32'(sel[1]), 32'd0);
            chk("idle_data", 32'(data[1]), 32'd0);
            chk("idle_valid", 32'(valid[1]), 32'd0);
            chk("idle_busy", 32'(busy[1]), 32'd0);
        end
        cont[1] = 1'b1;
        repeat (3) begin
            step();
            chk("cont_alone_busy", 32'(busy[1]), 32'd0);
        end
        cont[1] = 1'b0;

        trig(1);
        do_scan(1, 16'hA5C3, 16'hA5C3, -1, -1, -1, w);
        chk("single_word", 32'(data[1]), 32'h0000A5C3);
        accept(1, 20, 1'b0, w);

        trig(1);
        do_scan(1, 16'hA5C3, 16'hA5C3, -1, 5, 17, w);
        chk("ignored_start_word", 32'(data[1]), 32'h0000A5C3);
        accept(1, 0, 1'b0, w);

        for (int i = 0; i < 16; i++) begin
            p0 = 16'd1 << i;
            trig(0);
            do_scan(0, p0, p0, -1, -1, -1, w);
            chk("onehot_word", 32'(data[0]), 32'(p0));
            accept(0, int'($urandom_range(0, 3)), 1'b0, w);
        end

        for (int i = 0; i < 4; i++) begin
            p0 = 16'($urandom);
            p1 = 16'($urandom);
            trig(0);
            do_scan(0, p0, p1, int'($urandom_range(0, 15)), -1, -1, w);
            accept(0, int'($urandom_range(0, 3)), 1'b0, w);
            trig(1);
            do_scan(1, p1, p0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), -1, w);
            accept(1, int'($urandom_range(0, 5)), 1'b0, w);
        end

        ready[1] = 1'b1;
        cont[1] = 1'b1;
        trig(1);
        do_scan(1, 16'hFFFF, 16'hFFFF, -1, -1, -1, w);
        chk("cont_first_word", 32'(data[1]), 32'h0000FFFF);
        accept(1, 0, 1'b1, w);
        do_scan(1, 16'hFFFF, 16'h1234, 15, -1, -1, w);
        chk("cont_mixed_word", 32'(data[1]), 32'h0000127F);
        accept(1, 0, 1'b0, w);

        trig(1);
        pat[1] = 16'hA5C3;
        repeat (12) step();
        chk("pre_rst_sel", 32'(sel[1]), 32'd6);
        chk("pre_rst_data", 32'(data[1]), 32'h00000003);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_sel", 32'(sel[1]), 32'd0);
        chk("async_data", 32'(data[1]), 32'd0);
        chk("async_valid", 32'(valid[1]), 32'd0);
        chk("async_busy", 32'(busy[1]), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        trig(1);
        do_scan(1, 16'hA5C3, 16'hA5C3, -1, -1, -1, w);
        chk("post_rst_word", 32'(data[1]), 32'h0000A5C3);
        accept(1, 2, 1'b0, w);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mux16_scan_ctrl.md
Name: mux16_scan_ctrl

Overview:
- Sequential scan controller paired with the 16:1 mux (`mux4`: I[15:0], Sel[3:0], Out).
- Drives Sel through channels 0..15, waits a settle time on each channel, samples the mux output, and assembles the 16 one-bit samples into a word.
- Sits upstream of the mux on Sel and downstream of it on Out.
- Delivers each completed word on a valid/ready handshake to the consuming logic.

Parameters:
- SETTLE_CYCLES, 1, extra clock cycles Sel is held stable before Mux_out is sampled. Legal range 0..15.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- Start  input  1  request one scan; sampled only in IDLE.
- Cont  input  1  continuous mode; restart a scan automatically after each accepted word.
- Mux_out  input  1  Out of the 16:1 mux.
- Sel  output  4  channel select to the mux.
- Data  output  16  assembled word; Data[k] = Mux_out sampled while Sel==k.
- Valid  output  1  Data holds a complete word.
- Ready  input  1  consumer accepts Data when Valid && Ready at a rising edge.
- Busy  output  1  high in SETTLE or SAMPLE.

Behaviour:
- Reset (Rst_n=0, asynchronous): state=IDLE, Sel=0, Data=0, Valid=0, Busy=0, settle counter=0.
- Reset mid-scan aborts immediately; partial data is discarded (Data=0).
- States: IDLE, SETTLE, SAMPLE, DONE. Busy=1 exactly in SETTLE and SAMPLE.
- IDLE, Start=1 at an edge:
  - Sel<=0, Data<=0, counter<=SETTLE_CYCLES.
  - Go to SETTLE, or to SAMPLE if SETTLE_CYCLES==0.
- SETTLE: counter decrements each edge. On the edge where counter==1 (decremented to 0), go to SAMPLE.
- SAMPLE, one edge:
  - Data[Sel]<=Mux_out.
  - If Sel==15: go to DONE, Valid<=1.
  - Else: Sel<=Sel+1, counter<=SETTLE_CYCLES, go to SETTLE (or stay in SAMPLE if SETTLE_CYCLES==0).
- Each channel holds Sel stable for exactly SETTLE_CYCLES+1 cycles. Mux_out is sampled at the last edge of that window.
- Latency: from the Start edge to the edge that sets Valid is exactly 16*(SETTLE_CYCLES+1) cycles. With the default, that is 32 cycles.
- DONE:
  - Valid=1; Data and Sel (=15) held stable.
  - Ready may be high before Valid; acceptance requires both high at the same edge.
  - Valid && Ready at an edge: Valid<=0.
  - If Cont=1 or Start=1 at that same edge, begin a new scan on that edge (Sel<=0, Data<=0, enter SETTLE/SAMPLE). No idle cycle is inserted.
  - Otherwise go to IDLE with Sel<=0.
- Start while Busy or in DONE is ignored; no queuing. Exception: a DONE-state acceptance edge, as above.
- Cont=1 in IDLE alone does not start a scan; Start is required for the first scan.
- Cont is re-evaluated only at acceptance edges.
- Deassertion of Cont mid-scan lets the current scan complete.
- Sel never exceeds 15 and never wraps inside a scan. Sel returns to 0 only on a new scan or on return to IDLE.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset then idle: Rst_n low 3 cycles, then high for 10 cycles with Start=0 -> Sel=0, Data=0, Valid=0, Busy=0 throughout.
- Single scan: bench instantiates mux4 with I=16'hA5C3, SETTLE_CYCLES=1, Start one-cycle pulse, Ready=0 -> Sel steps 0..15 holding each for 2 cycles; Valid rises exactly 32 cycles after the Start edge; Data=16'hA5C3; Data/Valid remain stable for 20 further cycles until Ready=1, after which Valid=0 next edge and state is IDLE.
- Zero settle: SETTLE_CYCLES=0, I=16'h0001 then walk a one-hot across all 16 positions (16 scans) -> each scan Valid after 16 cycles; Data equals I each time.
- Continuous back-to-back: Cont=1, Ready=1 constant, I=16'hFFFF then changed to 16'h1234 mid second scan -> first word 16'hFFFF; Sel returns to 0 on the acceptance edge with no gap; second word shows the mix of old and new I at the channels sampled before and after the change, matching the bench model bit-for-bit.
- Ignored Start: Start pulses while Busy at cycles 5 and 17 -> no restart; Valid still at cycle 32; Sel sequence unchanged.
- Asynchronous reset mid-scan: assert Rst_n=0 between edges at cycle 13 -> outputs clear immediately (before next edge); after release, a new Start yields a correct full word 16'hA5C3.
